axi_ram_responder: RTL and testbench

AXI4 slave memory model that answers the bursts issued by the L2 cache's AXI master port, standing in for DDR in simulation and in FPGA builds without a DDR controller. It accepts one transaction at a time on a single-ID interface, stores data in an internal word-addressed RAM with byte enables, and returns OKAY/SLVERR write and read responses with full-rate burst streaming.

---
 rtl/axi_ram_responder.sv | 184 ++++++++++++++++++
 tb/tb_axi_ram_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_responder.sv
// Single-ID AXI4 slave backed by a word-addressed RAM with byte enables.
// Serves one burst at a time; used as a DDR stand-in for the L2 cache master.
module axi_ram_responder #(
   parameter int ADDR_W     = 24,
   parameter int DATA_W     = 32,
   parameter int MEM_ADDR_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                axi_awid,
   input  logic [ADDR_W-1:0]   axi_awaddr,
   input  logic [7:0]          axi_awlen,
   input  logic [1:0]          axi_awburst,
   input  logic                axi_awvalid,
   output logic                axi_awready,
   input  logic [DATA_W-1:0]   axi_wdata,
   input  logic [DATA_W/8-1:0] axi_wstrb,
   input  logic                axi_wlast,
   input  logic                axi_wvalid,
   output logic                axi_wready,
   output logic                axi_bid,
   output logic [1:0]          axi_bresp,
   output logic                axi_bvalid,
   input  logic                axi_bready,
   input  logic                axi_arid,
   input  logic [ADDR_W-1:0]   axi_araddr,
   input  logic [7:0]          axi_arlen,
   input  logic [1:0]          axi_arburst,
   input  logic                axi_arvalid,
   output logic                axi_arready,
   output logic                axi_rid,
   output logic [DATA_W-1:0]   axi_rdata,
   output logic [1:0]          axi_rresp,
   output logic                axi_rlast,
   output logic                axi_rvalid,
   input  logic                axi_rready,
   output logic [2:0]          o_dbg_state
);

   localparam int STRB_W = DATA_W / 8;
   localparam int BYTE_W = $clog2(STRB_W);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never waits on ready, and payload is held until accepted.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WDATA = 3'd1,
      WRESP = 3'd2,
      RREAD = 3'd3,
      RDATA = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_id;
   logic [MEM_ADDR_W-1:0] r_idx;
   logic [7:0]            r_len;
   logic [7:0]            r_cnt;
   logic                  r_fixed;
   logic                  r_err;
   logic [DATA_W-1:0]     r_rdata;
   logic [DATA_W-1:0]     r_mem [0:(1<<MEM_ADDR_W)-1];

   logic                  w_last_beat;
   logic                  w_aw_hs;
   logic                  w_ar_hs;
   logic                  w_w_hs;
   logic                  w_b_hs;
   logic                  w_r_hs;
   logic                  w_rd_en;
   logic [MEM_ADDR_W-1:0] w_idx_next;
   logic [MEM_ADDR_W-1:0] w_rd_idx;
   logic                  w_unused_ok;

   assign w_last_beat = (r_cnt == r_len);
   assign w_aw_hs     = axi_awvalid & axi_awready;
   assign w_ar_hs     = axi_arvalid & axi_arready;
   assign w_w_hs      = axi_wvalid & axi_wready;
   assign w_b_hs      = axi_bvalid & axi_bready;
   assign w_r_hs      = axi_rvalid & axi_rready;
   assign w_idx_next  = r_fixed ? r_idx : r_idx + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      axi_awready = 1'b0;
      axi_arready = 1'b0;
      axi_wready  = 1'b0;
      axi_bvalid  = 1'b0;
      axi_rvalid  = 1'b0;
      axi_rlast   = 1'b0;
      case (r_state)
         IDLE: begin
            if (axi_awvalid) begin
               axi_awready = 1'b1;
               w_next      = WDATA;
            end else if (axi_arvalid) begin
               axi_arready = 1'b1;
               w_next      = RREAD;
            end
         end
         WDATA: begin
            axi_wready = 1'b1;
            if (axi_wvalid && w_last_beat) w_next = WRESP;
         end
         WRESP: begin
            axi_bvalid = 1'b1;
            if (axi_bready) w_next = IDLE;
         end
         RREAD: w_next = RDATA;
         RDATA: begin
            axi_rvalid = 1'b1;
            axi_rlast  = w_last_beat;
            if (axi_rready && w_last_beat) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Burst length, not wlast, decides when the burst ends; wlast only flags errors.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_id    <= 1'b0;
         r_idx   <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_fixed <= 1'b0;
         r_err   <= 1'b0;
      end else if (w_aw_hs) begin
         r_id    <= axi_awid;
         r_idx   <= axi_awaddr[MEM_ADDR_W+BYTE_W-1:BYTE_W];
         r_len   <= axi_awlen;
         r_fixed <= (axi_awburst == 2'd0);
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else if (w_ar_hs) begin
         r_id    <= axi_arid;
         r_idx   <= axi_araddr[MEM_ADDR_W+BYTE_W-1:BYTE_W];
         r_len   <= axi_arlen;
         r_fixed <= (axi_arburst == 2'd0);
         r_cnt   <= '0;
      end else if (w_w_hs) begin
         r_cnt <= r_cnt + 1'b1;
         r_idx <= w_idx_next;
         if (axi_wlast != w_last_beat) r_err <= 1'b1;
      end else if (w_r_hs) begin
         r_cnt <= r_cnt + 1'b1;
         r_idx <= w_idx_next;
      end else if (w_b_hs) begin
         r_err <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_w_hs) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (axi_wstrb[b]) r_mem[r_idx][8*b +: 8] <= axi_wdata[8*b +: 8];
         end
      end
   end

   // Prefetch the next word on each accepted beat so the burst streams at full rate.
   assign w_rd_en  = (r_state == RREAD) | (w_r_hs & ~w_last_beat);
   assign w_rd_idx = (r_state == RREAD) ? r_idx : w_idx_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          r_rdata <= '0;
      else if (w_rd_en) r_rdata <= r_mem[w_rd_idx];
   end

   assign axi_bid     = r_id;
   assign axi_bresp   = ((r_state == WRESP) && r_err) ? 2'b10 : 2'b00;
   assign axi_rid     = r_id;
   assign axi_rdata   = r_rdata;
   assign axi_rresp   = 2'b00;
   assign o_dbg_state = r_state;

   assign w_unused_ok = &{1'b0, axi_awaddr, axi_araddr, axi_awburst, axi_arburst};

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed bench for axi_ram_responder: drivers issue bursts and queue expected
// B/R responses; a negedge monitor pops and compares on every handshake.
module tb_axi_ram_responder;

   localparam int ADDR_W     = 24;
   localparam int DATA_W     = 32;
   localparam int MEM_ADDR_W = 16;
   localparam int STRB_W     = DATA_W / 8;
   localparam int TMO        = 200;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              axi_awid;
   logic [ADDR_W-1:0] axi_awaddr;
   logic [7:0]        axi_awlen;
   logic [1:0]        axi_awburst;
   logic              axi_awvalid;
   logic              axi_awready;
   logic [DATA_W-1:0] axi_wdata;
   logic [STRB_W-1:0] axi_wstrb;
   logic              axi_wlast;
   logic              axi_wvalid;
   logic              axi_wready;
   logic              axi_bid;
   logic [1:0]        axi_bresp;
   logic              axi_bvalid;
   logic              axi_bready;
   logic              axi_arid;
   logic [ADDR_W-1:0] axi_araddr;
   logic [7:0]        axi_arlen;
   logic [1:0]        axi_arburst;
   logic              axi_arvalid;
   logic              axi_arready;
   logic              axi_rid;
   logic [DATA_W-1:0] axi_rdata;
   logic [1:0]        axi_rresp;
   logic              axi_rlast;
   logic              axi_rvalid;
   logic              axi_rready;
   logic [2:0]        o_dbg_state;

   always #5 clk = ~clk;

   axi_ram_responder #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_ADDR_W(MEM_ADDR_W)
   ) dut (
      .clk(clk), .rst(rst),
      .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
      .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
      .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
      .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
      .o_dbg_state(o_dbg_state)
   );

   int n_checks = 0;
   int n_errs   = 0;

   logic [2:0]        exp_b_q[$];   // {bid, bresp}
   logic [DATA_W+1:0] exp_r_q[$];   // {rid, rlast, rdata}

   logic [DATA_W-1:0] w_data_tab [256];
   logic [STRB_W-1:0] w_strb_tab [256];
   logic              w_last_tab [256];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_errs++;
      $display("FAIL %s: no handshake within %0d cycles", name, TMO);
   endtask

   task automatic push_r(input logic id, input logic last, input logic [DATA_W-1:0] data);
      exp_r_q.push_back({id, last, data});
   endtask

   task automatic set_beat(input int b, input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s,
                           input logic l);
      w_data_tab[b] = d;
      w_strb_tab[b] = s;
      w_last_tab[b] = l;
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [2:0]        b_e;
   logic [DATA_W+1:0] r_e;
   logic              stall_pend = 1'b0;
   logic [DATA_W:0]   stall_val;

   always @(negedge clk) begin
      if (rst) begin
         stall_pend = 1'b0;
      end else begin
         if (axi_bvalid && axi_bready) begin
            if (exp_b_q.size() == 0) begin
               n_checks++; n_errs++;
               $display("FAIL b_unexpected: got resp %0d with nothing expected", axi_bresp);
            end else begin
               b_e = exp_b_q.pop_front();
               check("b_id_resp", {61'd0, axi_bid, axi_bresp}, {61'd0, b_e});
            end
         end
         if (stall_pend)
            check("r_stall_hold", {31'd0, axi_rvalid, axi_rlast, axi_rdata}, {31'd0, 1'b1, stall_val});
         if (axi_rvalid && axi_rready) begin
            if (exp_r_q.size() == 0) begin
               n_checks++; n_errs++;
               $display("FAIL r_unexpected: got data %h with nothing expected", axi_rdata);
            end else begin
               r_e = exp_r_q.pop_front();
               check("r_beat", {30'd0, axi_rid, axi_rlast, axi_rdata}, {30'd0, r_e});
            end
         end
         stall_pend = axi_rvalid && !axi_rready;
         stall_val  = {axi_rlast, axi_rdata};
      end
   end

   // ---------------- drivers ----------------
   task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic id, input logic [1:0] exp_resp);
      int t;
      exp_b_q.push_back({id, exp_resp});
      axi_awaddr = addr; axi_awlen = len; axi_awburst = burst; axi_awid = id;
      axi_awvalid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!axi_awready && t < TMO);
      if (!axi_awready) timeout_fail("aw_accept");
      if (axi_arvalid) check("aw_wins_arready", {63'd0, axi_arready}, 64'd0);
      @(posedge clk); #1;
      axi_awvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         axi_wdata = w_data_tab[b]; axi_wstrb = w_strb_tab[b]; axi_wlast = w_last_tab[b];
         axi_wvalid = 1'b1;
         @(negedge clk);
         check("wready_beat", {63'd0, axi_wready}, 64'd1);
         t = 0;
         while (!axi_wready && t < TMO) begin @(negedge clk); t++; end
         if (!axi_wready) timeout_fail("w_accept");
         @(posedge clk); #1;
      end
      axi_wvalid = 1'b0; axi_wlast = 1'b0;
      @(negedge clk);
      check("bvalid_after_last", {63'd0, axi_bvalid}, 64'd1);
      t = 0;
      while (!axi_bvalid && t < TMO) begin @(negedge clk); t++; end
      if (!axi_bvalid) timeout_fail("b_valid");
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic id, input bit toggle);
      int t;
      int got;
      int n_neg;
      int cyc;
      axi_araddr = addr; axi_arlen = len; axi_arburst = burst; axi_arid = id;
      axi_arvalid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!axi_arready && t < TMO);
      if (!axi_arready) timeout_fail("ar_accept");
      @(posedge clk); #1;
      axi_arvalid = 1'b0;
      cyc = 0; got = 0; n_neg = 0;
      axi_rready = 1'b1;
      while (got <= int'(len) && n_neg < 4 * TMO) begin
         @(negedge clk);
         n_neg++;
         if (axi_rvalid && axi_rready) got++;
         if (got <= int'(len)) begin
            @(posedge clk); #1;
            cyc++;
            axi_rready = toggle ? (cyc % 3 == 0) : 1'b1;
         end
      end
      if (got <= int'(len)) timeout_fail("r_burst");
      if (!toggle) check("read_cycles", 64'(n_neg), 64'(int'(len) + 2));
      @(posedge clk); #1;
      axi_rready = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      axi_awid = 0; axi_awaddr = '0; axi_awlen = '0; axi_awburst = 2'd1; axi_awvalid = 0;
      axi_wdata = '0; axi_wstrb = '0; axi_wlast = 0; axi_wvalid = 0; axi_bready = 1'b1;
      axi_arid = 0; axi_araddr = '0; axi_arlen = '0; axi_arburst = 2'd1; axi_arvalid = 0;
      axi_rready = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs",
            {13'd0, axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid, axi_rlast,
             axi_bresp, axi_rresp, axi_bid, axi_rid, axi_rdata, o_dbg_state}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // single-beat write then read
      set_beat(0, 32'hDEADBEEF, 4'hF, 1'b1);
      do_write(24'h000100, 8'd0, 2'd1, 1'b0, 2'b00);
      push_r(1'b0, 1'b1, 32'hDEADBEEF);
      do_read(24'h000100, 8'd0, 2'd1, 1'b0, 1'b0);

      // 16-beat INCR write, full-rate read, then stalled read
      for (int i = 0; i < 16; i++) set_beat(i, 32'(i), 4'hF, i == 15);
      do_write(24'h002000, 8'd15, 2'd1, 1'b1, 2'b00);
      for (int i = 0; i < 16; i++) push_r(1'b1, i == 15, 32'(i));
      do_read(24'h002000, 8'd15, 2'd1, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) push_r(1'b1, i == 15, 32'(i));
      do_read(24'h002000, 8'd15, 2'd1, 1'b1, 1'b1);

      // byte-enable merge
      set_beat(0, 32'h11223344, 4'hF, 1'b1);
      do_write(24'h000040, 8'd0, 2'd1, 1'b0, 2'b00);
      set_beat(0, 32'hAABBCCDD, 4'h5, 1'b1);
      do_write(24'h000040, 8'd0, 2'd1, 1'b0, 2'b00);
      push_r(1'b0, 1'b1, 32'h11BB33DD);
      do_read(24'h000040, 8'd0, 2'd1, 1'b0, 1'b0);

      // simultaneous AW/AR to the same address: write first, read sees new data
      axi_araddr = 24'h000080; axi_arlen = 8'd0; axi_arburst = 2'd1; axi_arid = 1'b0;
      axi_arvalid = 1'b1;
      set_beat(0, 32'hCAFEF00D, 4'hF, 1'b1);
      do_write(24'h000080, 8'd0, 2'd1, 1'b1, 2'b00);
      push_r(1'b0, 1'b1, 32'hCAFEF00D);
      do_read(24'h000080, 8'd0, 2'd1, 1'b0, 1'b0);

      // early wlast on beat 1 of a 4-beat burst: all beats land, SLVERR
      for (int i = 0; i < 4; i++) set_beat(i, 32'hA0 + 32'(i), 4'hF, i == 1);
      do_write(24'h000300, 8'd3, 2'd1, 1'b0, 2'b10);
      for (int i = 0; i < 4; i++) push_r(1'b0, i == 3, 32'hA0 + 32'(i));
      do_read(24'h000300, 8'd3, 2'd1, 1'b0, 1'b0);

      // FIXED burst keeps hitting one word; neighbour untouched
      set_beat(0, 32'h55555555, 4'hF, 1'b1);
      do_write(24'h000504, 8'd0, 2'd1, 1'b0, 2'b00);
      for (int i = 0; i < 3; i++) set_beat(i, 32'(i + 1), 4'hF, i == 2);
      do_write(24'h000500, 8'd2, 2'd0, 1'b0, 2'b00);
      push_r(1'b0, 1'b0, 32'd3);
      push_r(1'b0, 1'b1, 32'h55555555);
      do_read(24'h000500, 8'd1, 2'd1, 1'b0, 1'b0);

      // index wraps past the top word; upper address bits alias
      set_beat(0, 32'h77777777, 4'hF, 1'b0);
      set_beat(1, 32'h88888888, 4'hF, 1'b1);
      do_write(24'h03FFFC, 8'd1, 2'd2, 1'b0, 2'b00);
      push_r(1'b0, 1'b1, 32'h88888888);
      do_read(24'h000000, 8'd0, 2'd1, 1'b0, 1'b0);
      push_r(1'b0, 1'b1, 32'h77777777);
      do_read(24'hC3FFFC, 8'd0, 2'd1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) push_r(1'b1, i == 2, 32'hDEADBEEF);
      do_read(24'h040100, 8'd2, 2'd0, 1'b1, 1'b0);

      // reset in the middle of a stalled read burst
      axi_rready = 1'b0;
      axi_araddr = 24'h002000; axi_arlen = 8'd15; axi_arburst = 2'd1; axi_arid = 1'b1;
      axi_arvalid = 1'b1;
      @(negedge clk);
      check("ar_ready_idle", {63'd0, axi_arready}, 64'd1);
      @(posedge clk); #1;
      axi_arvalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rdata_state", {60'd0, axi_rvalid, o_dbg_state}, {60'd0, 1'b1, 3'd4});
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("reset_mid_read",
            {13'd0, axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid, axi_rlast,
             axi_bresp, axi_rresp, axi_bid, axi_rid, axi_rdata, o_dbg_state}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      push_r(1'b0, 1'b1, 32'hDEADBEEF);
      do_read(24'h000100, 8'd0, 2'd1, 1'b0, 1'b0);

      repeat (5) @(negedge clk);
      check("b_queue_drained", 64'(exp_b_q.size()), 64'd0);
      check("r_queue_drained", 64'(exp_r_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
